// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send and
// clocks one command byte plus odd parity and stop out on the device's clock.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int START_TIMEOUT  = 750000,
   parameter int FRAME_TIMEOUT  = 100000,
   parameter int FILTER_CYCLES  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       PS2_CLK_in,
   input  logic       PS2_DAT_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_ack_ok,
   output logic       tx_error
);

   localparam int MAX_A  = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
   localparam int MAX_L  = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
   localparam int CW     = $clog2(MAX_L + 1);
   localparam int FW     = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] INH_END   = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] START_END = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0] FRAME_END = CW'(FRAME_TIMEOUT - 1);
   localparam logic [FW-1:0] FLT_END   = FW'(FILTER_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_START, S_REQ, S_SHIFT, S_WAIT_IDLE, S_DONE, S_ERR
   } state_t;

   state_t          state, state_next;
   logic            clk_s1, clk_s, dat_s1, dat_s;
   logic            clk_f, clk_f_d, fall;
   logic [FW-1:0]   fcnt;
   logic [CW-1:0]   cnt;
   logic [3:0]      bitcnt;
   logic [7:0]      data_q;
   logic            parity_q, ack_q;
   logic [9:0]      frame_bits;
   logic            clk_oe_d, dat_oe_d;

   // Pad synchronisers and CLK stability filter; idle bus level is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_s1  <= 1'b1;
         clk_s   <= 1'b1;
         dat_s1  <= 1'b1;
         dat_s   <= 1'b1;
         clk_f   <= 1'b1;
         clk_f_d <= 1'b1;
         fcnt    <= '0;
      end else begin
         clk_s1  <= PS2_CLK_in;
         clk_s   <= clk_s1;
         dat_s1  <= PS2_DAT_in;
         dat_s   <= dat_s1;
         clk_f_d <= clk_f;
         if (clk_s == clk_f) begin
            fcnt <= '0;
         end else if (fcnt == FLT_END) begin
            clk_f <= clk_s;
            fcnt  <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   assign fall       = clk_f_d & ~clk_f;
   assign frame_bits = {1'b1, parity_q, data_q};

   // State register plus the registered pad enables.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         state      <= state_next;
         ps2_clk_oe <= clk_oe_d;
         ps2_dat_oe <= dat_oe_d;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (tx_valid) state_next = S_INHIBIT;
         S_INHIBIT:   if (cnt == INH_END) state_next = S_START;
         S_START:     state_next = S_REQ;
         S_REQ: begin
            if (fall)                    state_next = S_SHIFT;
            else if (cnt == START_END)   state_next = S_ERR;
         end
         S_SHIFT: begin
            if (fall && bitcnt == 4'd10) state_next = S_WAIT_IDLE;
            else if (cnt == FRAME_END)   state_next = S_ERR;
         end
         S_WAIT_IDLE: begin
            if (clk_f && dat_s)          state_next = S_DONE;
            else if (cnt == FRAME_END)   state_next = S_ERR;
         end
         S_DONE:      state_next = S_IDLE;
         S_ERR:       state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   // Next values of the pad enables are decoded from the state being entered.
   always_comb begin
      clk_oe_d  = (state_next == S_INHIBIT) || (state_next == S_START);
      dat_oe_d  = 1'b0;
      case (state_next)
         S_START, S_REQ: dat_oe_d = 1'b1;
         S_SHIFT: begin
            dat_oe_d = ps2_dat_oe;
            if (state == S_SHIFT && fall && bitcnt <= 4'd9) dat_oe_d = ~frame_bits[bitcnt];
         end
         default: dat_oe_d = 1'b0;
      endcase
      tx_ready  = (state == S_IDLE);
      busy      = (state != S_IDLE);
      tx_done   = (state == S_DONE);
      tx_ack_ok = (state == S_DONE) && ack_q;
      tx_error  = (state == S_ERR);
   end

   // The frame timer keeps running from SHIFT into WAIT_IDLE; any other transition restarts it.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q   <= '0;
         parity_q <= 1'b0;
         ack_q    <= 1'b0;
         bitcnt   <= '0;
         cnt      <= '0;
      end else begin
         if (state == S_IDLE && tx_valid) begin
            data_q   <= tx_data;
            parity_q <= ~^tx_data;
            ack_q    <= 1'b0;
         end
         if (state == S_REQ && fall)
            bitcnt <= '0;
         else if (state == S_SHIFT && fall && bitcnt != 4'd11)
            bitcnt <= bitcnt + 1'b1;
         if (state == S_SHIFT && fall && bitcnt == 4'd10)
            ack_q <= ~dat_s;
         if (state != state_next && !(state == S_SHIFT && state_next == S_WAIT_IDLE))
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain device model clocks frames out of the host,
// and sampled frames / ACK results are checked against a scoreboard queue.
module tb_ps2_host_tx;

   localparam int INH  = 40;
   localparam int ST   = 1500;
   localparam int FT   = 1200;
   localparam int FLT  = 4;
   localparam int HALF = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_ack_ok, tx_error;
   logic       clk_pad, dat_pad;

   int compared = 0;
   int mismatched = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   logic [10:0] exp_q[$];
   logic        exp_ack_q[$];

   assign clk_pad = ~ps2_clk_oe & dev_clk;
   assign dat_pad = ~ps2_dat_oe & dev_dat;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_TIMEOUT (ST),
      .FRAME_TIMEOUT (FT),
      .FILTER_CYCLES (FLT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .PS2_CLK_in(clk_pad),
      .PS2_DAT_in(dat_pad),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy      (busy),
      .tx_done   (tx_done),
      .tx_ack_ok (tx_ack_ok),
      .tx_error  (tx_error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (tx_done === 1'b1)  done_cnt <= done_cnt + 1;
      if (tx_error === 1'b1) err_cnt  <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line order as the device sees it: start, data LSB first, odd parity, stop.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
   endfunction

   task automatic send_req(input logic [7:0] b);
      int n = 0;
      @(negedge clock);
      while (tx_ready !== 1'b1 && n < 1000) begin
         @(negedge clock);
         n++;
      end
      check("req_ready", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
   endtask

   task automatic device(input int nfalls, input bit ack, input bit glitch, output logic [10:0] frame);
      int inh = 0;
      bit dat_first = 1'b0;
      frame = '0;
      for (int n = 0; n < INH + 2000; n++) begin
         @(negedge clock);
         if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) inh++;
         if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) dat_first = 1'b1;
         if (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) break;
      end
      check("release_seen", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
      check("inhibit_cycles", inh, INH);
      check("dat_low_before_clk_release", dat_first, 1);
      for (int i = 0; i < nfalls; i++) begin
         repeat (HALF) @(negedge clock);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         if (i < 11) frame[i] = dat_pad;
         dev_clk = 1'b1;
         if (i == 10 && ack) dev_dat = 1'b0;
         if (i == 11) dev_dat = 1'b1;
         if (glitch && i == 3) begin
            repeat (5) @(negedge clock);
            dev_clk = 1'b0;
            repeat (FLT - 2) @(negedge clock);
            dev_clk = 1'b1;
         end
      end
   endtask

   task automatic wait_done();
      bit   seen = 1'b0;
      logic ea;
      int   e0 = err_cnt;
      ea = exp_ack_q.pop_front();
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         if (tx_done === 1'b1) begin
            seen = 1'b1;
            check("ack_ok", tx_ack_ok, ea);
            break;
         end
      end
      check("done_seen", seen, 1);
      @(negedge clock);
      check("no_error_in_frame", err_cnt, e0);
      check("ready_after_done", tx_ready, 1);
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input bit glitch);
      logic [10:0] got;
      logic [10:0] e;
      exp_q.push_back(frame_of(b));
      exp_ack_q.push_back(ack);
      fork
         send_req(b);
         device(12, ack, glitch, got);
      join
      e = exp_q.pop_front();
      check("frame_bits", got, e);
      wait_done();
   endtask

   initial begin
      logic [10:0] got;
      logic [10:0] e;
      int k;
      int d0;
      int r0;
      bit seen;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_outputs", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_ack_ok, tx_error}, 7'b1000000);
      reset = 1'b0;
      @(negedge clock);
      check("idle_outputs", {tx_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);

      // Normal frames, parity variants, missing ACK, glitch on CLK
      run_frame(8'hED, 1'b1, 1'b0);
      run_frame(8'h01, 1'b1, 1'b0);
      run_frame(8'hFF, 1'b1, 1'b0);
      run_frame(8'h3C, 1'b0, 1'b0);
      run_frame(8'h96, 1'b1, 1'b1);

      // Device never clocks: error exactly ST cycles after CLK release
      d0 = done_cnt;
      k  = 0;
      fork
         send_req(8'h55);
         begin
            for (int n = 0; n < 100 && ps2_clk_oe !== 1'b1; n++) @(negedge clock);
            for (int n = 0; n < INH + 100 && ps2_clk_oe !== 1'b0; n++) @(negedge clock);
            while (tx_error !== 1'b1 && k < ST + 100) begin
               @(negedge clock);
               k++;
            end
         end
      join
      check("start_timeout_cycles", k, ST);
      check("start_err_lines", {tx_error, ps2_clk_oe, ps2_dat_oe}, 3'b100);
      @(negedge clock);
      check("start_err_ready", tx_ready, 1);
      check("start_err_no_done", done_cnt, d0);

      // Device stalls mid-frame: frame timeout
      d0   = done_cnt;
      seen = 1'b0;
      fork
         send_req(8'h5A);
         device(6, 1'b1, 1'b0, got);
      join
      for (int n = 0; n < FT + 200; n++) begin
         @(negedge clock);
         if (tx_error === 1'b1) begin
            seen = 1'b1;
            check("frame_err_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
            break;
         end
      end
      check("frame_err_seen", seen, 1);
      @(negedge clock);
      check("frame_err_ready", tx_ready, 1);
      check("frame_err_no_done", done_cnt, d0);

      // Reset mid-frame after fall 4 (data bit 3 of 0x00 is being driven low)
      d0 = done_cnt;
      r0 = err_cnt;
      fork
         send_req(8'h00);
         device(5, 1'b1, 1'b0, got);
      join
      check("pre_reset_dat_oe", ps2_dat_oe, 1);
      reset = 1'b1;
      @(negedge clock);
      check("reset_release", {ps2_clk_oe, ps2_dat_oe, busy, tx_ready}, 4'b0001);
      reset = 1'b0;
      repeat (100) @(negedge clock);
      check("reset_no_done", done_cnt, d0);
      check("reset_no_error", err_cnt, r0);

      // tx_valid while busy is ignored; original byte goes out intact
      exp_q.push_back(frame_of(8'hA5));
      exp_ack_q.push_back(1'b1);
      fork
         send_req(8'hA5);
         device(12, 1'b1, 1'b0, got);
         begin
            for (int n = 0; n < 100 && busy !== 1'b1; n++) @(negedge clock);
            repeat (3) @(negedge clock);
            check("busy_ready_low", tx_ready, 0);
            tx_data  = 8'h00;
            tx_valid = 1'b1;
            @(negedge clock);
            tx_valid = 1'b0;
         end
      join
      e = exp_q.pop_front();
      check("busy_frame_bits", got, e);
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
